// File: rtl/apb_slave_regfile.sv
// APB completer register bank.
//
// reg0 returns ID_VALUE and reg1 returns the 16-bit completed-transfer count. Both are read-only.
// reg2 .. NUM_REGS-1 are read/write word registers. Every access phase inserts WAIT_CYCLES wait
// states before P_READY goes high. The bank answers with P_SLVERR for a misaligned address, an
// out-of-range address, or a write to a read-only register.
//
// Ports:
//   H_CLK, H_RESET_n       clock, asynchronous active-low reset
//   P_SELx, P_ENABLE       APB select and access-phase strobe
//   P_WRITE, P_ADDR        direction and byte address (sampled in the setup cycle only)
//   P_WDATA                write data (sampled in the setup cycle only)
//   P_RDATA                read data, non-zero only on a completing, error-free read
//   P_READY, P_SLVERR      completion and error response (P_SLVERR qualified by P_READY)
module apb_slave_regfile #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter int unsigned           WAIT_CYCLES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                  H_CLK,
  input  logic                  H_RESET_n,
  input  logic                  P_SELx,
  input  logic                  P_ENABLE,
  input  logic                  P_WRITE,
  input  logic [ADDR_WIDTH-1:0] P_ADDR,
  input  logic [DATA_WIDTH-1:0] P_WDATA,
  output logic [DATA_WIDTH-1:0] P_RDATA,
  output logic                  P_READY,
  output logic                  P_SLVERR
);

  localparam int unsigned IdxW  = $clog2(NUM_REGS);
  localparam int unsigned WaitW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(WAIT_CYCLES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                  state_q, state_d;
  logic [WaitW-1:0]        wait_q, wait_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [15:0]             xfer_cnt_q, xfer_cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS-1:2];

  logic                  setup;
  logic [IdxW-1:0]       idx_in;
  logic                  err_in;
  logic                  ready;
  logic                  commit_wr;
  logic [DATA_WIDTH-1:0] rd_mux;

  // A setup phase is accepted in either state: in StAccess it restarts the transfer.
  assign setup  = P_SELx & ~P_ENABLE;
  assign idx_in = P_ADDR[IdxW+1:2];
  assign err_in = (|P_ADDR[1:0])
                | (|(P_ADDR >> (IdxW + 2)))
                | (P_WRITE & (idx_in[IdxW-1:1] == '0));

  assign ready     = (state_q == StAccess) & P_SELx & P_ENABLE & (wait_q == '0);
  assign commit_wr = ready & write_q & ~err_q;

  // State register
  always_ff @(posedge H_CLK or negedge H_RESET_n) begin
    if (!H_RESET_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (setup) state_d = StAccess;
      end
      StAccess: begin
        if (!P_SELx) begin
          state_d = StIdle;
        end else if (!P_ENABLE) begin
          state_d = StAccess;
        end else if (wait_q == '0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: transfer latches, wait counter, transfer counter
  always_comb begin
    idx_d      = idx_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    wait_d     = wait_q;
    xfer_cnt_d = xfer_cnt_q;
    if (setup) begin
      idx_d   = idx_in;
      write_d = P_WRITE;
      wdata_d = P_WDATA;
      err_d   = err_in;
      wait_d  = WaitLoad;
    end else if ((state_q == StAccess) && P_SELx && P_ENABLE && (wait_q != '0)) begin
      wait_d = wait_q - WaitW'(1);
    end
    if (ready && !err_q) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge H_CLK or negedge H_RESET_n) begin
    if (!H_RESET_n) begin
      wait_q     <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      xfer_cnt_q <= '0;
      for (int unsigned i = 2; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wait_q     <= wait_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      xfer_cnt_q <= xfer_cnt_d;
      for (int unsigned i = 2; i < NUM_REGS; i++) begin
        if (commit_wr && (idx_q == IdxW'(i))) regs_q[i] <= wdata_q;
      end
    end
  end

  // Read mux; reg1 shows the count before this transfer's increment
  always_comb begin
    rd_mux = '0;
    if (idx_q == IdxW'(0)) begin
      rd_mux = ID_VALUE;
    end else if (idx_q == IdxW'(1)) begin
      rd_mux = {{(DATA_WIDTH-16){1'b0}}, xfer_cnt_q};
    end else begin
      for (int unsigned i = 2; i < NUM_REGS; i++) begin
        if (idx_q == IdxW'(i)) rd_mux = regs_q[i];
      end
    end
  end

  // Outputs
  always_comb begin
    P_READY  = ready;
    P_SLVERR = ready & err_q;
    P_RDATA  = (ready && !write_q && !err_q) ? rd_mux : '0;
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

  logic        H_CLK = 1'b0;
  logic        H_RESET_n;
  logic        P_SELx, P_ENABLE, P_WRITE;
  logic [31:0] P_ADDR, P_WDATA, P_RDATA;
  logic        P_READY, P_SLVERR;

  int tests  = 0;
  int failed = 0;

  always #5 H_CLK = ~H_CLK;

  apb_slave_regfile #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (16),
    .WAIT_CYCLES(1),
    .ID_VALUE   (32'hA9B0_0001)
  ) dut (
    .H_CLK    (H_CLK),
    .H_RESET_n(H_RESET_n),
    .P_SELx   (P_SELx),
    .P_ENABLE (P_ENABLE),
    .P_WRITE  (P_WRITE),
    .P_ADDR   (P_ADDR),
    .P_WDATA  (P_WDATA),
    .P_RDATA  (P_RDATA),
    .P_READY  (P_READY),
    .P_SLVERR (P_SLVERR)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; the access-phase address/data are scrambled to prove they are ignored.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int waits);
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = wr; P_ADDR = addr; P_WDATA = wdata;
    @(negedge H_CLK);
    P_ENABLE = 1'b1; P_ADDR = ~addr; P_WDATA = ~wdata;
    waits = -1; rdata = 'x; err = 1'bx;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (P_READY) begin
        waits = i; rdata = P_RDATA; err = P_SLVERR;
        break;
      end
      @(negedge H_CLK);
    end
  endtask

  task automatic xfer_chk(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          w;
    xfer(wr, addr, wdata, rd, er, w);
    check({name, " waits"}, 32'(w), 32'd1);
    check({name, " rdata"}, rd, exp_rdata);
    check({name, " slverr"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  task automatic go_idle();
    @(negedge H_CLK);
    P_SELx = 1'b0; P_ENABLE = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    H_RESET_n = 1'b0;
    P_SELx = 1'b0; P_ENABLE = 1'b0; P_WRITE = 1'b0; P_ADDR = '0; P_WDATA = '0;

    // {wr, addr, wdata, expected rdata, expected slverr}; applied back-to-back from reset
    tbl.push_back('{1'b0, 32'h00, 32'h0,         32'hA9B0_0001, 1'b0}); // cnt -> 1
    tbl.push_back('{1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0,         1'b0}); // cnt -> 2
    tbl.push_back('{1'b0, 32'h04, 32'h0,         32'h2,         1'b0}); // cnt -> 3
    tbl.push_back('{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0}); // cnt -> 4
    tbl.push_back('{1'b1, 32'h04, 32'h1,         32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h41, 32'h1111_1111, 32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h40, 32'h2222_2222, 32'h0,         1'b1});
    tbl.push_back('{1'b1, 32'h00, 32'h3333_3333, 32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h41, 32'h0,         32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h100, 32'h0,        32'h0,         1'b1});
    tbl.push_back('{1'b0, 32'h04, 32'h0,         32'h4,         1'b0}); // cnt -> 5
    tbl.push_back('{1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0}); // cnt -> 6
    tbl.push_back('{1'b1, 32'h0C, 32'hCAFE_F00D, 32'h0,         1'b0}); // cnt -> 7
    tbl.push_back('{1'b0, 32'h0C, 32'h0,         32'hCAFE_F00D, 1'b0}); // cnt -> 8
    tbl.push_back('{1'b1, 32'h3C, 32'h1234_5678, 32'h0,         1'b0}); // cnt -> 9
    tbl.push_back('{1'b0, 32'h3C, 32'h0,         32'h1234_5678, 1'b0}); // cnt -> 10
    tbl.push_back('{1'b0, 32'h04, 32'h0,         32'hA,         1'b0}); // cnt -> 11

    repeat (2) @(negedge H_CLK);
    #1;
    check("reset ready", {31'd0, P_READY}, 32'd0);
    check("reset slverr", {31'd0, P_SLVERR}, 32'd0);
    check("reset rdata", P_RDATA, 32'd0);
    H_RESET_n = 1'b1;

    foreach (tbl[i]) begin
      xfer_chk($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata,
               tbl[i].exp_rdata, tbl[i].exp_err);
    end
    go_idle();

    // Abort: drop P_SELx in the wait cycle of a write to reg4
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = 32'h10; P_WDATA = 32'h55;
    @(negedge H_CLK);
    P_ENABLE = 1'b1;
    #1 check("abort wait ready", {31'd0, P_READY}, 32'd0);
    @(negedge H_CLK);
    P_SELx = 1'b0; P_ENABLE = 1'b0;
    #1 check("abort ready", {31'd0, P_READY}, 32'd0);
    xfer_chk("abort rd10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0); // cnt -> 12

    // Restart: a second setup in the access phase replaces the first transfer
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = 32'h14; P_WDATA = 32'h11;
    @(negedge H_CLK);
    P_ENABLE = 1'b1;
    #1 check("restart w1 ready", {31'd0, P_READY}, 32'd0);
    @(negedge H_CLK);
    P_ENABLE = 1'b0; P_WDATA = 32'h22;
    #1 check("restart setup ready", {31'd0, P_READY}, 32'd0);
    @(negedge H_CLK);
    P_ENABLE = 1'b1;
    #1 check("restart w2 ready", {31'd0, P_READY}, 32'd0);
    @(negedge H_CLK);
    #1 check("restart done ready", {31'd0, P_READY}, 32'd1);
    check("restart done slverr", {31'd0, P_SLVERR}, 32'd0); // cnt -> 13
    xfer_chk("restart rd14", 1'b0, 32'h14, 32'h0, 32'h22, 1'b0); // cnt -> 14
    xfer_chk("restart cnt", 1'b0, 32'h04, 32'h0, 32'hE, 1'b0);   // cnt -> 15
    go_idle();

    // Counter wrap: preload 0xFFFF, one counted transfer wraps it to 0
    @(negedge H_CLK);
    force dut.xfer_cnt_d = 16'hFFFF;
    @(negedge H_CLK);
    release dut.xfer_cnt_d;
    xfer_chk("wrap pre", 1'b0, 32'h04, 32'h0, 32'hFFFF, 1'b0);   // cnt -> 0
    xfer_chk("wrap post", 1'b0, 32'h04, 32'h0, 32'h0, 1'b0);     // cnt -> 1
    go_idle();

    // Reset in the completing access cycle: the write is lost and state clears at once
    @(negedge H_CLK);
    P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = 32'h08; P_WDATA = 32'h99;
    @(negedge H_CLK);
    P_ENABLE = 1'b1;
    @(negedge H_CLK);
    #1 check("rst pre ready", {31'd0, P_READY}, 32'd1);
    #1 H_RESET_n = 1'b0;
    #1 check("rst ready", {31'd0, P_READY}, 32'd0);
    check("rst slverr", {31'd0, P_SLVERR}, 32'd0);
    P_SELx = 1'b0; P_ENABLE = 1'b0;
    @(negedge H_CLK);
    H_RESET_n = 1'b1;
    xfer_chk("rst rd08", 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);      // cnt -> 1
    xfer_chk("rst rd3c", 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);      // cnt -> 2
    xfer_chk("rst cnt", 1'b0, 32'h04, 32'h0, 32'h2, 1'b0);
    go_idle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
